// File: rtl/am_err_pkg.sv
// Shared types and constants for the approximate-multiplier error monitor.
package am_err_pkg;

  // Default operand width. Modules derive their own widths from their OP_W parameter.
  localparam int DEF_OP_W   = 32;
  localparam int DEF_PROD_W = 2 * DEF_OP_W;
  localparam int DEF_ERR_W  = DEF_PROD_W + 1;

  // Number of datapath stages between sample acceptance and the statistics update.
  localparam int PIPE_LAT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/am_err_stage.sv
// Three-stage datapath: register the sample, form the exact product, then form
// the signed error e = z - x*y and its magnitude. Valids are flushable.
module am_err_stage
  import am_err_pkg::*;
#(
  parameter int OP_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [OP_W-1:0]   x_i,
  input  logic [OP_W-1:0]   y_i,
  input  logic [2*OP_W-1:0] z_i,
  output logic              busy_o,
  output logic              out_valid_o,
  output logic [2*OP_W:0]   err_o,
  output logic [2*OP_W:0]   abs_o,
  output logic [OP_W-1:0]   x_o,
  output logic [OP_W-1:0]   y_o
);

  localparam int PW = 2 * OP_W;
  localparam int EW = PW + 1;

  logic [PIPE_LAT-1:0] vld_q;
  logic [OP_W-1:0]     x1_q, y1_q, x2_q, y2_q, x3_q, y3_q;
  logic [PW-1:0]       z1_q, z2_q, p2_q;
  logic [EW-1:0]       e3_q, a3_q;
  logic [EW-1:0]       e_d, a_d;

  // Error and magnitude from stage-2 values; magnitude of a 65-bit error always fits 65 bits.
  always_comb begin
    e_d = {1'b0, z2_q} - {1'b0, p2_q};
    a_d = e_d[EW-1] ? (~e_d + 1'b1) : e_d;
  end

  // Valid shift register; flush drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       vld_q <= '0;
    else if (flush_i) vld_q <= '0;
    else              vld_q <= {vld_q[PIPE_LAT-2:0], in_valid_i};
  end

  // Data stages: capture, exact product, signed error and magnitude.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_q <= '0; y1_q <= '0; z1_q <= '0;
      x2_q <= '0; y2_q <= '0; z2_q <= '0; p2_q <= '0;
      x3_q <= '0; y3_q <= '0; e3_q <= '0; a3_q <= '0;
    end else begin
      x1_q <= x_i;  y1_q <= y_i;  z1_q <= z_i;
      x2_q <= x1_q; y2_q <= y1_q; z2_q <= z1_q; p2_q <= x1_q * y1_q;
      x3_q <= x2_q; y3_q <= y2_q; e3_q <= e_d;  a3_q <= a_d;
    end
  end

  assign busy_o      = |vld_q;
  assign out_valid_o = vld_q[PIPE_LAT-1];
  assign err_o       = e3_q;
  assign abs_o       = a3_q;
  assign x_o         = x3_q;
  assign y_o         = y3_q;

endmodule

// File: rtl/am_err_monitor.sv
// Error-statistics monitor for approximate multipliers: window FSM, input
// handshake and saturating accumulators over the error datapath.
// Handshake: a sample is accepted on a rising edge where in_valid && in_ready;
// in_ready is a function of state and accepted count only, never of in_valid.
module am_err_monitor
  import am_err_pkg::*;
#(
  parameter int OP_W  = 32,
  parameter int SUM_W = 96,   // must be at least 2*OP_W+1
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic [CNT_W-1:0]  cfg_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   x,
  input  logic [OP_W-1:0]   y,
  input  logic [2*OP_W-1:0] z,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  stat_count,
  output logic [CNT_W-1:0]  stat_nz,
  output logic [SUM_W-1:0]  stat_sum_abs,
  output logic [SUM_W-1:0]  stat_sum_err,
  output logic [2*OP_W:0]   stat_max_abs,
  output logic [OP_W-1:0]   stat_max_x,
  output logic [OP_W-1:0]   stat_max_y,
  output state_e            dbg_state
);

  localparam int EW = 2 * OP_W + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cfg_q, acc_q, acc_d, acc_inc;
  logic             busy_q, done_q;
  logic             fire, pipe_busy, s3_valid, zero_stats;
  logic [EW-1:0]    s3_err, s3_abs;
  logic [OP_W-1:0]  s3_x, s3_y;

  logic [CNT_W-1:0] cnt_q, nz_q;
  logic [SUM_W-1:0] sabs_q, serr_q, sabs_d, serr_d;
  logic [EW-1:0]    max_q;
  logic [OP_W-1:0]  max_x_q, max_y_q;
  logic [SUM_W:0]   abs_sum, err_sum;

  assign in_ready   = (state_q == RUN) && (acc_q < cfg_q);
  assign fire       = in_valid && in_ready;
  assign acc_inc    = acc_q + CNT_W'(fire);
  assign zero_stats = clear || (start && (state_q == IDLE || state_q == DONE));

  am_err_stage #(.OP_W(OP_W)) u_stage (
    .clk(clk), .rst_n(rst_n), .flush_i(clear), .in_valid_i(fire),
    .x_i(x), .y_i(y), .z_i(z),
    .busy_o(pipe_busy), .out_valid_o(s3_valid), .err_o(s3_err), .abs_o(s3_abs),
    .x_o(s3_x), .y_o(s3_y)
  );

  // Next-state and accepted-count logic; clear overrides start.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin state_d = RUN; acc_d = '0; end
        RUN: begin
          acc_d = acc_inc;
          if (acc_inc == cfg_q) state_d = DRAIN;
        end
        DRAIN: if (!pipe_busy) state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM registers with registered busy/done; cfg_n latched when a window is armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE; cfg_q <= '0; acc_q <= '0; busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      busy_q  <= (state_d == RUN) || (state_d == DRAIN);
      done_q  <= (state_d == DONE) && (state_q != DONE);
      if (!clear && start && (state_q == IDLE || state_q == DONE)) cfg_q <= cfg_n;
    end
  end

  // Saturating sums: unsigned carry-out clamps to all-ones; signed overflow clamps to min/max.
  always_comb begin
    abs_sum = {1'b0, sabs_q} + {{(SUM_W + 1 - EW){1'b0}}, s3_abs};
    err_sum = {serr_q[SUM_W-1], serr_q} + {{(SUM_W + 1 - EW){s3_err[EW-1]}}, s3_err};
    sabs_d  = abs_sum[SUM_W] ? {SUM_W{1'b1}} : abs_sum[SUM_W-1:0];
    serr_d  = err_sum[SUM_W-1:0];
    if (err_sum[SUM_W] != err_sum[SUM_W-1])
      serr_d = err_sum[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
  end

  // Statistics accumulate once per stage-3 sample; max keeps the first of a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0; nz_q <= '0; sabs_q <= '0; serr_q <= '0;
      max_q <= '0; max_x_q <= '0; max_y_q <= '0;
    end else if (zero_stats) begin
      cnt_q <= '0; nz_q <= '0; sabs_q <= '0; serr_q <= '0;
      max_q <= '0; max_x_q <= '0; max_y_q <= '0;
    end else if (s3_valid) begin
      cnt_q  <= cnt_q + 1'b1;
      nz_q   <= nz_q + CNT_W'(s3_err != '0);
      sabs_q <= sabs_d;
      serr_q <= serr_d;
      if (s3_abs > max_q) begin
        max_q <= s3_abs; max_x_q <= s3_x; max_y_q <= s3_y;
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign stat_count   = cnt_q;
  assign stat_nz      = nz_q;
  assign stat_sum_abs = sabs_q;
  assign stat_sum_err = serr_q;
  assign stat_max_abs = max_q;
  assign stat_max_x   = max_x_q;
  assign stat_max_y   = max_y_q;
  assign dbg_state    = state_q;

endmodule
